mult_sched: RTL and testbench
=============================

# mult_sched

Request scheduler that shares the single 5-bit unsigned multiplier datapath among several requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time using round-robin priority and drives the multiplier operand registers. It waits the multiplier's fixed latency, captures the 10-bit product, and returns it with the requester ID over a valid/ready response channel. It sits between the requester-facing logic and the multiplier core inside `top`.

## Interface

- `NREQ`, 4: number of requesters; must be ≥2.
- `W`, 5: operand width; product width is 2·W.
- `MUL_LAT`, 1: cycles from operands at `mul_a`/`mul_b` to a valid `mul_p`; 0 means combinational.
- `IDW`, $clog2(NREQ): response ID width; derived, not overridden.

Ports:

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: bit i means requester i has an operand pair.
- `req_ready` out NREQ: grant strobe, one-hot or zero.
- `req_a` in NREQ·W: operand A of requester i at bits [i·W +: W].
- `req_b` in NREQ·W: operand B, packed the same way as `req_a`.
- `mul_a`, `mul_b` out W: registered operands to the multiplier.
- `mul_p` in 2W: product from the multiplier.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_prod` out 2W: captured product.
- `busy` out 1: high in any state other than IDLE.

## Operation

- The FSM has three states: IDLE, WAIT and RESP. Exactly one transaction is in flight at a time.
- **IDLE**
  - If any `req_valid` bit is set, the arbiter picks the first set bit scanning from `ptr` upward, modulo NREQ. Call it g.
  - `req_ready[g]`=1 combinationally in that cycle; this is the handshake.
  - On the clock edge: `mul_a`/`mul_b` ← operands of g, `rsp_id` ← g, `ptr` ← (g+1) mod NREQ, `cnt` ← MUL_LAT, next state WAIT.
  - If no `req_valid` bit is set, the block stays in IDLE and `req_ready` is all zeros.
- **WAIT**
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: `rsp_prod` ← `mul_p`, next state RESP.
  - `req_ready` is 0 throughout.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_prod` and `rsp_id` stay stable until `rsp_valid`&`rsp_ready`.
  - On that handshake the next state is IDLE.
  - No new grant is issued in the handshake cycle.
- **Requester rules**
  - A requester must hold `req_valid` and its operands stable until it sees `req_ready`.
  - Operands are sampled only in the grant cycle; later changes are ignored.
  - Deasserting `req_valid` before the grant is legal. That requester is simply not granted.
- **Arithmetic:** unsigned only. The block does not modify the product; `rsp_prod` is `mul_p` bit-for-bit.
- **Reset**, including mid-transaction:
  - All of these clear: `mul_a`, `mul_b`, `rsp_prod`, `rsp_id` and `ptr` go to 0; `rsp_valid` and `busy` go to 0; `req_ready` goes to 0; state goes to IDLE.
  - An in-flight transaction is dropped silently and produces no response.

## Timing

- Grant in cycle T0.
- `mul_a`/`mul_b` are valid from T1.
- Product is captured at the end of cycle T1+MUL_LAT.
- `rsp_valid` rises in T2+MUL_LAT.
- With immediate `rsp_ready`, the next grant is possible in T3+MUL_LAT. Peak throughput is one operation per 3+MUL_LAT cycles.
- `req_ready` depends combinationally on `req_valid`, state and `ptr` only. There is no path from `rsp_ready` to `req_ready`.
- `rsp_valid` is a register output and carries no combinational input path.

## Structure

- **Package `mult_sched_pkg`**
  - State enum `sched_state_t` with values IDLE, WAIT, RESP.
  - Default constants `W_DEF`=5 and `NREQ_DEF`=4.
- **Sub-module `rr_arbiter`**
  - Parameter NREQ.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, binary `gnt_idx`, `any`.
  - Purely combinational. `ptr` is held in `mult_sched`.

## Test plan

- **Single request.** Default parameters, behavioural multiplier with 1-cycle latency. Req0 a=31, b=31 granted at T0.
  - Expect `rsp_valid` at T3 with `rsp_prod`=961 and `rsp_id`=0.
  - Expect `busy` high during T1–T3.
- **All requesters at once.** All four assert valid continuously, operands a=i+1, b=2.
  - Expect grants in order 0,1,2,3,0.
  - Expect products 2,4,6,8,2.
- **Fairness.** Req1 and req3 continuously valid, `ptr`=0.
  - Expect grants 1,3,1,3.
  - Req2 asserts mid-sequence after a grant of 1: expect the next grant to be 2.
- **Response backpressure.** Hold `rsp_ready` low for 5 cycles in RESP.
  - Expect `rsp_valid`, `rsp_prod` and `rsp_id` stable throughout.
  - Expect `req_ready`=0 throughout even with `req_valid` high.
- **Reset mid-transaction.** Assert `rst_n` low during WAIT.
  - Expect all outputs 0 immediately, asynchronously.
  - After release: no stale response, and the first grant goes to the lowest valid index.
- **Latency corners.** Repeat the single-request case with MUL_LAT=0 and MUL_LAT=3.
  - Expect `rsp_valid` at T2 and T5 respectively.
  - Expect 17×23=391 captured correctly in both.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// ---------------------------------------------------------------------------
// mult_sched_pkg
// Shared types and default constants for the multiplier request scheduler.
//   sched_state_t : scheduler FSM state (IDLE, WAIT, RESP)
//   W_DEF         : default operand width
//   NREQ_DEF      : default number of requesters
// ---------------------------------------------------------------------------
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int W_DEF    = 5;
  localparam int NREQ_DEF = 4;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Scans the request vector starting
// at index ptr and wrapping modulo NREQ; the first set bit wins. The pointer
// itself is owned and advanced by the instantiating block.
// Ports:
//   req     in  NREQ : request vector
//   ptr     in  IDW  : index with highest priority this cycle
//   gnt     out NREQ : one-hot grant, zero when no request
//   gnt_idx out IDW  : binary index of the granted requester
//   any     out 1    : at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  int idx;

  // Walk priority order ptr, ptr+1, ... and latch onto the first hit only.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// ---------------------------------------------------------------------------
// mult_sched
// Shares one W-bit unsigned multiplier among NREQ requesters. One transaction
// is in flight at a time: grant (IDLE), wait MUL_LAT cycles for the product
// (WAIT), then hold the response until it is accepted (RESP).
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is the grant
//   req_a, req_b        : packed operands, requester i at [i*W +: W]
//   mul_a, mul_b        : registered operands towards the multiplier
//   mul_p               : product returned by the multiplier
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_prod    : owning requester and captured product
//   busy                : scheduler is not idle
// ---------------------------------------------------------------------------
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_b,
  input  logic [2*W-1:0]            mul_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*W-1:0]            rsp_prod,
  output logic                      busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  sched_state_t     state_q;
  logic [IDW-1:0]   ptr_q;
  logic [CNTW-1:0]  cnt_q;
  logic [W-1:0]     mul_a_q;
  logic [W-1:0]     mul_b_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [2*W-1:0]   rsp_prod_q;
  logic             rsp_valid_q;
  logic             busy_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;

  logic [W-1:0]     op_a [NREQ];
  logic [W-1:0]     op_b [NREQ];

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*W +: W];
    assign op_b[i] = req_b[i*W +: W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Grant only while idle; reset also forces it low because the state alone
  // would still read IDLE with requests pending.
  assign req_ready = (rst_n && (state_q == IDLE)) ? gnt : '0;

  // Scheduler FSM with all outputs registered. cnt_q counts down the
  // multiplier latency; the product is captured on the cycle it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            mul_a_q  <= op_a[gnt_idx];
            mul_b_q  <= op_b[gnt_idx];
            rsp_id_q <= gnt_idx;
            ptr_q    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            cnt_q    <= CNTW'(MUL_LAT);
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNTW'(1);
          end else begin
            rsp_prod_q  <= mul_p;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_sched.sv
// ---------------------------------------------------------------------------
// tb_mult_sched
// Drives three scheduler instances (multiplier latency 1, 0 and 3) from shared
// requester inputs. The latency-1 instance carries the main scenarios; the
// other two are compared in the latency corner scenario. Expected grants and
// products come from a round-robin reference model kept in the bench.
// ---------------------------------------------------------------------------
module tb_mult_sched;

  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int IDW  = 2;
  localparam int LAT1 = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ*W-1:0] reqA;
  logic [NREQ*W-1:0] reqB;
  logic              rspReady;

  logic [W-1:0]      opA [NREQ];
  logic [W-1:0]      opB [NREQ];

  logic [NREQ-1:0]   reqReady, reqReady0, reqReady3;
  logic [W-1:0]      mulA, mulB, mulA0, mulB0, mulA3, mulB3;
  logic [2*W-1:0]    mulP, mulP0, mulP3;
  logic              rspValid, rspValid0, rspValid3;
  logic [IDW-1:0]    rspId, rspId0, rspId3;
  logic [2*W-1:0]    rspProd, rspProd0, rspProd3;
  logic              busy, busy0, busy3;
  logic [2*W-1:0]    pipe3 [3];

  int checks = 0;
  int errors = 0;
  int modelPtr = 0;

  always #5 clk = ~clk;

  // Pack the per-requester operand arrays onto the flat buses.
  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign reqA[i*W +: W] = opA[i];
    assign reqB[i*W +: W] = opB[i];
  end

  // Behavioural multipliers with latency 1, 0 and 3.
  always_ff @(posedge clk) mulP <= (2*W)'(mulA) * (2*W)'(mulB);
  assign mulP0 = (2*W)'(mulA0) * (2*W)'(mulB0);
  always_ff @(posedge clk) begin
    pipe3[0] <= (2*W)'(mulA3) * (2*W)'(mulB3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mulP3 = pipe3[2];

  mult_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(LAT1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .mul_a(mulA), .mul_b(mulB), .mul_p(mulP),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
    .rsp_prod(rspProd), .busy(busy)
  );

  mult_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady0),
    .req_a(reqA), .req_b(reqB), .mul_a(mulA0), .mul_b(mulB0), .mul_p(mulP0),
    .rsp_valid(rspValid0), .rsp_ready(rspReady), .rsp_id(rspId0),
    .rsp_prod(rspProd0), .busy(busy0)
  );

  mult_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady3),
    .req_a(reqA), .req_b(reqB), .mul_a(mulA3), .mul_b(mulB3), .mul_p(mulP3),
    .rsp_valid(rspValid3), .rsp_ready(rspReady), .rsp_id(rspId3),
    .rsp_prod(rspProd3), .busy(busy3)
  );

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid index scanning upward from ptr, wrapping.
  function automatic int expGrant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Every output of the main instance must read zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rsp_valid"}, 32'(rspValid), 0);
    checkOutput({tag, "_busy"},      32'(busy), 0);
    checkOutput({tag, "_req_ready"}, 32'(reqReady), 0);
    checkOutput({tag, "_mul_a"},     32'(mulA), 0);
    checkOutput({tag, "_mul_b"},     32'(mulB), 0);
    checkOutput({tag, "_rsp_prod"},  32'(rspProd), 0);
    checkOutput({tag, "_rsp_id"},    32'(rspId), 0);
  endtask

  // Entered just after a falling edge; leaves just after a falling edge.
  task automatic applyReset();
    reqValid = '0;
    rspReady = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    modelPtr = 0;
    #1;
  endtask

  // One full transaction on the latency-1 instance: grant, latency, product,
  // optional backpressure, and the response handshake.
  task automatic applyStimulus(input logic [NREQ-1:0] vmask, input int rspDelay, input bit scramble);
    int g;
    int c;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    reqValid = vmask;
    rspReady = 1'b0;
    #1;
    g = expGrant(vmask, modelPtr);
    if (g < 0) begin
      checkOutput("idle_req_ready", 32'(reqReady), 0);
      @(negedge clk);
      #1;
      checkOutput("idle_busy", 32'(busy), 0);
      return;
    end
    checkOutput("grant", 32'(reqReady), 32'(1) << g);
    checkOutput("busy_t0", 32'(busy), 0);
    ea = opA[g];
    eb = opB[g];
    modelPtr = (g + 1) % NREQ;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
      if (c == 1 && scramble) begin
        opA[g] = W'($urandom_range(0, 31));
        opB[g] = W'($urandom_range(0, 31));
      end
      checkOutput("busy_wait", 32'(busy), 1);
    end while (!rspValid && c < 20);
    checkOutput("rsp_latency", 32'(c), 32'(2 + LAT1));
    checkOutput("rsp_prod", 32'(rspProd), 32'(ea) * 32'(eb));
    checkOutput("rsp_id", 32'(rspId), 32'(g));
    for (int k = 0; k < rspDelay; k++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_rsp_valid", 32'(rspValid), 1);
      checkOutput("bp_rsp_prod", 32'(rspProd), 32'(ea) * 32'(eb));
      checkOutput("bp_rsp_id", 32'(rspId), 32'(g));
      checkOutput("bp_req_ready", 32'(reqReady), 0);
    end
    rspReady = 1'b1;
    #1;
    checkOutput("hs_no_grant", 32'(reqReady), 0);
    @(negedge clk);
    rspReady = 1'b0;
    #1;
    checkOutput("hs_rsp_valid_low", 32'(rspValid), 0);
  endtask

  initial begin
    int g;
    int first0;
    int first3;
    rst_n    = 1'b1;
    reqValid = '0;
    rspReady = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    @(negedge clk);

    // Reset state
    applyReset();

    // Single request, 31*31
    opA[0] = 5'd31;
    opB[0] = 5'd31;
    applyStimulus(4'b0001, 0, 1'b0);

    // All requesters at once, a=i+1, b=2, starting from ptr 0
    applyReset();
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = W'(i + 1);
      opB[i] = 5'd2;
    end
    for (int n = 0; n < 5; n++) applyStimulus(4'b1111, 0, 1'b0);

    // Fairness between 1 and 3, then 2 joins after a grant of 1
    applyReset();
    applyStimulus(4'b1010, 0, 1'b0);
    applyStimulus(4'b1010, 0, 1'b0);
    applyStimulus(4'b1010, 0, 1'b0);
    applyStimulus(4'b1110, 0, 1'b0);
    applyStimulus(4'b1110, 0, 1'b0);

    // Response backpressure for 5 cycles
    opA[2] = 5'd19;
    opB[2] = 5'd27;
    applyStimulus(4'b0100, 5, 1'b0);

    // Reset during WAIT
    reqValid = 4'b1100;
    #1;
    g = expGrant(4'b1100, modelPtr);
    checkOutput("mid_grant", 32'(reqReady), 32'(1) << g);
    @(negedge clk);
    #1;
    checkOutput("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk);
    checkOutput("mid_no_stale", 32'(rspValid), 0);
    rst_n    = 1'b1;
    modelPtr = 0;
    opA[1] = 5'd9;
    opB[1] = 5'd13;
    applyStimulus(4'b0110, 0, 1'b0);

    // Randomized traffic, operands change after grant
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = W'($urandom_range(0, 31));
      opB[i] = W'($urandom_range(0, 31));
    end
    for (int n = 0; n < 24; n++) begin
      applyStimulus(NREQ'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
    end

    // Latency corners on the MUL_LAT=0 and MUL_LAT=3 instances
    applyReset();
    opA[0]   = 5'd17;
    opB[0]   = 5'd23;
    reqValid = 4'b0001;
    #1;
    checkOutput("lat0_grant", 32'(reqReady0), 1);
    checkOutput("lat3_grant", 32'(reqReady3), 1);
    first0 = -1;
    first3 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) reqValid = '0;
      if (rspValid0 && first0 < 0) first0 = c;
      if (rspValid3 && first3 < 0) first3 = c;
    end
    checkOutput("lat0_rsp_cycle", 32'(first0), 2);
    checkOutput("lat3_rsp_cycle", 32'(first3), 5);
    checkOutput("lat0_prod", 32'(rspProd0), 391);
    checkOutput("lat3_prod", 32'(rspProd3), 391);
    checkOutput("lat0_id", 32'(rspId0), 0);
    checkOutput("lat3_id", 32'(rspId3), 0);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    #1;
    checkOutput("lat0_done", 32'(rspValid0), 0);
    checkOutput("lat3_done", 32'(rspValid3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
